// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg
//   Definitions shared by the 16-bit cpu_alu and the multi-word sequencer
//   cpu_alu_wide_seq: opcode encodings, status-word bit positions, the
//   sequencer state type and small opcode classification helpers.
package cpu_alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBB = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_BIT  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_TST  = 4'hA;

  // Status word bit positions
  localparam int ST_CARRY = 0;
  localparam int ST_ZERO  = 1;
  localparam int ST_SIGN  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_BIT   = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_DONE = 2'd2
  } alu_seq_state_t;

  // Opcodes that the wide sequencer knows how to chain across words.
  function automatic logic wide_op_supported(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // Bitwise ops report only the zero flag at the wide level.
  function automatic logic is_logic_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu
//   Combinational 16-bit ALU.
//   Ports:
//     op          opcode (cpu_alu_pkg OP_*)
//     operand_in  left operand
//     operator_in right operand
//     status_in   incoming status; only the carry/borrow bit is consumed
//                 (by ADDC and SUBB)
//     result      16-bit result
//     status_out  {11'b0, bit, overflow, sign, zero, carry_borrow}
module cpu_alu
  import cpu_alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] operand_in,
  input  logic [15:0] operator_in,
  input  logic [15:0] status_in,
  output logic [15:0] result,
  output logic [15:0] status_out
);

  logic [16:0] wide;
  logic        carry;
  logic        ovf;
  logic        bit_flag;
  logic        cin;
  logic        unused_status_in;

  assign cin              = status_in[ST_CARRY];
  assign unused_status_in = ^status_in[15:1];

  always_comb begin
    wide     = '0;
    result   = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    bit_flag = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        wide   = {1'b0, operand_in} + {1'b0, operator_in} + {16'b0, (op == OP_ADDC) & cin};
        result = wide[15:0];
        carry  = wide[16];
        ovf    = ~(operand_in[15] ^ operator_in[15]) & (operand_in[15] ^ result[15]);
      end
      OP_SUB, OP_SUBB, OP_CMP: begin
        // 17-bit wrap: bit 16 set means the subtraction borrowed.
        wide   = {1'b0, operand_in} - {1'b0, operator_in} - {16'b0, (op == OP_SUBB) & cin};
        result = wide[15:0];
        carry  = wide[16];
        ovf    = (operand_in[15] ^ operator_in[15]) & (operand_in[15] ^ result[15]);
      end
      OP_AND: result = operand_in & operator_in;
      OP_OR:  result = operand_in | operator_in;
      OP_XOR: result = operand_in ^ operator_in;
      OP_NOT: result = ~operand_in;
      OP_BIT: begin
        result   = operand_in & (16'h0001 << operator_in[3:0]);
        bit_flag = |result;
      end
      OP_TST: result = operand_in & operator_in;
      default: ;
    endcase
    status_out           = '0;
    status_out[ST_CARRY] = carry;
    status_out[ST_ZERO]  = (result == 16'h0000);
    status_out[ST_SIGN]  = result[15];
    status_out[ST_OVF]   = ovf;
    status_out[ST_BIT]   = bit_flag;
  end

endmodule

// File: rtl/cpu_alu_wide_seq.sv
// cpu_alu_wide_seq
//   Runs 16..16*MAX_WORDS-bit operations through one cpu_alu, one word per
//   cycle, least significant word first, chaining carry/borrow and ANDing
//   the per-word zero flags.
//   Ports:
//     clock, reset           single clock, synchronous active-high reset
//     start / ready          request accepted when ready=1
//     op                     opcode (ADD, SUB, AND, OR, XOR, NOT, CMP)
//     words_m1               word count minus one (clamped to MAX_WORDS-1)
//     operand_in/operator_in left/right operands, word 0 least significant
//     done                   one-cycle completion pulse
//     error                  unsupported opcode (valid with done)
//     result                 wide result, words above words_m1 are zero
//     status                 {11'b0, bit, overflow, sign, zero, carry_borrow}
module cpu_alu_wide_seq
  import cpu_alu_pkg::*;
#(
  parameter  int MAX_WORDS = 4,
  localparam int IW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int W         = 16 * MAX_WORDS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [IW-1:0] words_m1,
  input  logic [W-1:0]  operand_in,
  input  logic [W-1:0]  operator_in,
  output logic          ready,
  output logic          done,
  output logic          error,
  output logic [W-1:0]  result,
  output logic [15:0]   status
);

  alu_seq_state_t state_reg, state_next;

  logic [3:0]    op_reg;
  logic [IW-1:0] last_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic          zero_acc_reg;
  logic [15:0]   res_words_reg [MAX_WORDS];
  logic [15:0]   status_reg;
  logic          error_reg;
  logic          done_reg;
  logic          ready_reg;

  logic [IW-1:0] words_clamped;
  logic [15:0]   a_words    [MAX_WORDS];
  logic [15:0]   b_words    [MAX_WORDS];
  logic [15:0]   init_words [MAX_WORDS];
  logic [3:0]    alu_op;
  logic [15:0]   alu_result;
  logic [15:0]   alu_status;
  logic [15:0]   store_word;
  logic [15:0]   final_status;
  logic          is_last;
  logic          accept;
  logic          op_ok;
  logic          unused_alu_status;

  // Only clamp when the words_m1 field can encode counts beyond MAX_WORDS.
  generate
    if ((1 << IW) > MAX_WORDS) begin : g_clamp
      assign words_clamped = (words_m1 > IW'(MAX_WORDS - 1)) ? IW'(MAX_WORDS - 1) : words_m1;
    end else begin : g_no_clamp
      assign words_clamped = words_m1;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_words
      assign a_words[gi]          = a_reg[16*gi +: 16];
      assign b_words[gi]          = b_reg[16*gi +: 16];
      assign result[16*gi +: 16]  = res_words_reg[gi];
      // Result preload for a rejected opcode: the operand, trimmed to length.
      if (gi == 0) begin : g_first
        assign init_words[gi] = operand_in[15:0];
      end else begin : g_rest
        assign init_words[gi] = (words_clamped >= IW'(gi)) ? operand_in[16*gi +: 16] : 16'h0000;
      end
    end
  endgenerate

  assign accept  = (state_reg == SEQ_IDLE) && start;
  assign op_ok   = wide_op_supported(op);
  assign is_last = (idx_reg == last_reg);

  // Word 0 starts the chain; later words consume the registered carry.
  always_comb begin
    alu_op = op_reg;
    case (op_reg)
      OP_ADD:         alu_op = (idx_reg == '0) ? OP_ADD : OP_ADDC;
      OP_SUB, OP_CMP: alu_op = (idx_reg == '0) ? OP_SUB : OP_SUBB;
      default: ;
    endcase
  end

  cpu_alu u_alu (
    .op          (alu_op),
    .operand_in  (a_words[idx_reg]),
    .operator_in (b_words[idx_reg]),
    .status_in   ({15'b0, carry_reg}),
    .result      (alu_result),
    .status_out  (alu_status)
  );

  assign unused_alu_status = ^{alu_status[15:ST_BIT]};

  // CMP only sets flags; the result keeps the left operand.
  assign store_word = (op_reg == OP_CMP) ? a_words[idx_reg] : alu_result;

  always_comb begin
    final_status          = '0;
    final_status[ST_ZERO] = zero_acc_reg & alu_status[ST_ZERO];
    if (!is_logic_op(op_reg)) begin
      final_status[ST_CARRY] = alu_status[ST_CARRY];
      final_status[ST_SIGN]  = alu_status[ST_SIGN];
      final_status[ST_OVF]   = alu_status[ST_OVF];
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= SEQ_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE: if (start)   state_next = op_ok ? SEQ_EXEC : SEQ_DONE;
      SEQ_EXEC: if (is_last) state_next = SEQ_DONE;
      SEQ_DONE:              state_next = SEQ_IDLE;
      default:               state_next = SEQ_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg       <= OP_ADD;
      last_reg     <= '0;
      idx_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      zero_acc_reg <= 1'b1;
      status_reg   <= '0;
      error_reg    <= 1'b0;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      for (int i = 0; i < MAX_WORDS; i++) res_words_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        op_reg       <= op;
        last_reg     <= words_clamped;
        a_reg        <= operand_in;
        b_reg        <= operator_in;
        idx_reg      <= '0;
        carry_reg    <= 1'b0;
        zero_acc_reg <= 1'b1;
        status_reg   <= '0;
        error_reg    <= !op_ok;
        done_reg     <= !op_ok;
        ready_reg    <= 1'b0;
        for (int i = 0; i < MAX_WORDS; i++) res_words_reg[i] <= op_ok ? 16'h0000 : init_words[i];
      end else if (state_reg == SEQ_EXEC) begin
        carry_reg              <= alu_status[ST_CARRY];
        zero_acc_reg           <= zero_acc_reg & alu_status[ST_ZERO];
        res_words_reg[idx_reg] <= store_word;
        idx_reg                <= idx_reg + 1'b1;
        if (is_last) begin
          status_reg <= final_status;
          done_reg   <= 1'b1;
        end
      end else if (state_reg == SEQ_DONE) begin
        ready_reg <= 1'b1;
      end
    end
  end

  assign ready  = ready_reg;
  assign done   = done_reg;
  assign error  = error_reg;
  assign status = status_reg;

endmodule

// File: tb/tb_cpu_alu_wide_seq.sv
// Testbench for cpu_alu_wide_seq: expected responses are queued at issue
// time from a wide-integer reference model; a monitor checks every done.
module tb_cpu_alu_wide_seq;

  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    op;
  logic [1:0]    words_m1;
  logic [16*MW-1:0] operand_in;
  logic [16*MW-1:0] operator_in;
  logic          ready;
  logic          done;
  logic          error;
  logic [16*MW-1:0] result;
  logic [15:0]   status;

  cpu_alu_wide_seq #(.MAX_WORDS(MW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .words_m1    (words_m1),
    .operand_in  (operand_in),
    .operator_in (operator_in),
    .ready       (ready),
    .done        (done),
    .error       (error),
    .result      (result),
    .status      (status)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [15:0] st;
    logic        err;
    int          cyc;
    logic [3:0]  op;
    int          n;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic bit supported(input logic [3:0] o);
    return (o == 4'h0) || (o == 4'h2) || (o == 4'h4) || (o == 4'h5) ||
           (o == 4'h6) || (o == 4'h7) || (o == 4'h9);
  endfunction

  // Reference: whole-operand arithmetic on N*16-bit integers.
  function automatic exp_t model(input logic [3:0] o, input int n, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [79:0] mask, am, bm, full, r;
    logic c, z, s, v;
    int msb;
    msb  = 16 * n - 1;
    mask = (80'd1 << (16 * n)) - 80'd1;
    am   = {16'h0, a} & mask;
    bm   = {16'h0, b} & mask;
    c = 1'b0; s = 1'b0; v = 1'b0; r = '0; full = '0;
    e.err = 1'b0;
    case (o)
      4'h0: begin
        full = am + bm;
        r = full & mask;
        c = full[16 * n];
        s = r[msb];
        v = (am[msb] == bm[msb]) && (r[msb] != am[msb]);
      end
      4'h2, 4'h9: begin
        full = am - bm;
        r = full & mask;
        c = (am < bm);
        s = r[msb];
        v = (am[msb] != bm[msb]) && (r[msb] != am[msb]);
      end
      4'h4: r = am & bm;
      4'h5: r = am | bm;
      4'h6: r = am ^ bm;
      4'h7: r = ~am & mask;
      default: e.err = 1'b1;
    endcase
    z = (r == 80'd0);
    if (e.err) begin
      e.res = am[63:0];
      e.st  = 16'h0000;
    end else begin
      e.res = (o == 4'h9) ? am[63:0] : r[63:0];
      e.st  = {11'b0, 1'b0, v, s, z, c};
    end
    e.op = o;
    e.n  = n;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_txn++;
        $display("txn %0d op=%h n=%0d result=%h status=%h error=%b cycle=%0d",
                 n_txn, e.op, e.n, result, status, error, cyc);
        chk("result", result, e.res);
        chk("status", {48'h0, status}, {48'h0, e.st});
        chk("error", {63'h0, error}, {63'h0, e.err});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("ready_during_done", {63'h0, ready}, 64'h0);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input int wm1, input logic [63:0] a,
                       input logic [63:0] b, input bit exp_done, input bit pulse);
    exp_t e;
    int w;
    int t_start;
    w = 0;
    while (!ready && w < 200) begin
      @(posedge clock); #1;
      w++;
    end
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: ready=%b required 1", ready);
    end
    op          = o;
    words_m1    = 2'(wm1);
    operand_in  = a;
    operator_in = b;
    start       = 1'b1;
    @(posedge clock); #1;
    t_start     = cyc - 1;
    start       = 1'b0;
    // Inputs are don't-care after acceptance: scramble them.
    operand_in  = {$urandom, $urandom};
    operator_in = {$urandom, $urandom};
    op          = 4'($urandom);
    words_m1    = 2'($urandom);
    if (exp_done) begin
      e = model(o, wm1 + 1, a, b);
      e.cyc = supported(o) ? (t_start + wm1 + 2) : (t_start + 1);
      q.push_back(e);
    end
    if (pulse) begin
      // Sampled while busy; must be ignored.
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bad_ops [9];
    logic [3:0] good_ops [7];
    bad_ops  = '{4'h1, 4'h3, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    good_ops = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};

    reset = 1'b1; start = 1'b0; op = '0; words_m1 = '0;
    operand_in = '0; operator_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", {63'h0, ready}, 64'h1);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_error", {63'h0, error}, 64'h0);
    chk("reset_result", result, 64'h0);
    chk("reset_status", {48'h0, status}, 64'h0);
    reset = 1'b0;

    // Directed cases
    issue(4'h0, 1, 64'h0000_FFFF, 64'h0000_0001, 1, 0);
    issue(4'h2, 1, 64'h0000_0000, 64'h0000_0001, 1, 0);
    issue(4'h0, 1, 64'h7FFF_FFFF, 64'h0000_0001, 1, 0);
    issue(4'h9, 3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1, 0);
    issue(4'h9, 3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 1, 0);
    issue(4'h6, 2, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1, 0);
    issue(4'h6, 2, 64'h0000_0001_0000_0000, 64'h0, 1, 0);
    issue(4'h8, 1, 64'h0000_0000_1234_5678, 64'h3, 1, 0);
    issue(4'h0, 3, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1, 1);
    issue(4'h0, 0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1, 0);

    // Reset in the middle of an N=4 ADD that would carry
    issue(4'h0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_ready", {63'h0, ready}, 64'h1);
    chk("midrst_done", {63'h0, done}, 64'h0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_status", {48'h0, status}, 64'h0);
    reset = 1'b0;
    issue(4'h0, 0, 64'h2, 64'h3, 1, 0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      logic [3:0]  o;
      logic [63:0] a, b;
      if ($urandom_range(9) == 0) o = bad_ops[$urandom_range(8)];
      else                        o = good_ops[$urandom_range(6)];
      a = {$urandom, $urandom};
      b = ($urandom_range(4) == 0) ? a : {$urandom, $urandom};
      issue(o, int'($urandom_range(3)), a, b, 1, ($urandom_range(3) == 0));
    end

    begin
      int w;
      w = 0;
      while (q.size() != 0 && w < 200) begin
        @(posedge clock);
        w++;
      end
      @(posedge clock); #1;
      chk("pending_drained", 64'(q.size()), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_alu_wide_seq.md
# cpu_alu_wide_seq

Multi-word arithmetic sequencer that runs 16/32/48/64-bit operations through the existing 16-bit `cpu_alu` one word per cycle. It chains the carry/borrow between words and accumulates the zero flag across words. It sits between the CPU execute stage and `cpu_alu`, owns the ALU for the duration of a wide operation, and returns a registered wide result plus a merged status word.

## Interface
- `MAX_WORDS`, default 4: maximum operand length in 16-bit words (1..8).
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request. Accepted only when `ready`=1.
- `op` in 4: ALU opcode (ADD 0, SUB 2, AND 4, OR 5, XOR 6, NOT 7, CMP 9).
- `words_m1` in $clog2(MAX_WORDS) (min 1): word count minus 1. Values ≥ MAX_WORDS are clamped to MAX_WORDS-1.
- `operand_in` in 16*MAX_WORDS: left operand, word 0 = least significant.
- `operator_in` in 16*MAX_WORDS: right operand.
- `ready` out 1: idle, can accept `start`.
- `done` out 1: one-cycle pulse; `result`/`status` valid from this cycle.
- `error` out 1: valid with `done`; unsupported opcode.
- `result` out 16*MAX_WORDS: wide result. Words above `words_m1` are 0.
- `status` out 16: {11'b0, bit, overflow, sign, zero, carry_borrow}.

## Operation
- FSM states:
  - IDLE (`ready`=1).
  - EXEC (word index `idx` counts 0..`words_m1`).
  - DONE (`done`=1 for one cycle).
- IDLE + `start`: latch `op`, `words_m1`, both operands. Clear `idx`, carry register, result register. Set zero accumulator to 1. Go to EXEC.
  - Unsupported op (1, 3, 8, A–F): skip EXEC and go straight to DONE with `error`=1, `result`=latched operand, `status`=0.
- EXEC: drive `cpu_alu` with word `idx` of each operand and `status_in`={15'b0, carry_reg}.
- Opcode issued per word:
  - ADD: ADD at idx 0, ADDC after.
  - SUB: SUB, then SUBB.
  - CMP: SUB, then SUBB, with result discarded; `result`=operand unchanged.
  - AND/OR/XOR/NOT: same op for every word.
- Each EXEC cycle:
  - carry_reg ← ALU carry_borrow.
  - zero_acc ← zero_acc & ALU zero.
  - Store result word `idx`; for CMP, store the operand word instead.
  - `idx`++.
- At `idx`==`words_m1`: capture sign and overflow from this final word, then go to DONE.
- Final `status`:
  - carry_borrow = last-word carry (borrow=1 on SUB/CMP underflow).
  - zero = zero_acc.
  - sign, overflow = last word.
  - bit = 0.
  - Logical ops: carry/sign/overflow = 0.
- DONE: `done`=1, then IDLE. `start` in DONE or EXEC is ignored (not queued).
- `result`, `status`, `error` hold their value until the next accepted `start`.
- Reset at any time, including mid-EXEC, aborts the operation. Reset values:
  - `ready`=1.
  - `done`=0, `error`=0.
  - `result`=0, `status`=0.
  - FSM=IDLE, `idx`=0.

## Timing
- Accept `start` at cycle T, N = `words_m1`+1:
  - EXEC covers T+1..T+N.
  - `done` asserts at T+N+1.
  - `ready` returns at T+N+2.
- Unsupported op: `done` asserts at T+1.
- Throughput: one operation per N+2 cycles. Single-word ops take 3 cycles start-to-start.
- ALU path is combinational inside one EXEC cycle. All outputs are registered.
- Operand inputs are don't-care after the accepting cycle.

## Structure
- Shared package `cpu_alu_pkg` holds:
  - Opcode localparams (ADD…TST).
  - Status bit indices (CARRY=0, ZERO=1, SIGN=2, OVF=3, BIT=4).
  - FSM state enum `alu_seq_state_t`.
  - `cpu_alu` and this block import it.
- Sub-module: one instance of the existing `cpu_alu`. No other sub-modules.

## Test plan
- ADD, N=2: 0x0000_FFFF + 0x0000_0001 → `result`=0x0001_0000, C=0, Z=0, S=0, V=0, `done` 3 cycles after `start`.
- SUB, N=2: 0x0000_0000 − 0x0000_0001 → 0xFFFF_FFFF, C=1, S=1, Z=0. Then ADD 0x7FFF_FFFF + 1 → 0x8000_0000, V=1, S=1.
- CMP, N=4: equal 64-bit operands 0x1234_5678_9ABC_DEF0 → `result`=operand, Z=1, C=0. Then low word differing only (…DEF1 vs …DEF0) → Z=0, C=1.
- XOR, N=3: 0x0001_0000_0000 with itself → `result`=0, Z=1. Also low word 0 and high word nonzero → Z=0 (accumulation check).
- `op`=8 (BIT) → `done` at T+1, `error`=1, `result`=operand, `status`=0. `start` pulsed during EXEC of another op is ignored.
- `reset` asserted at EXEC idx 1 of an N=4 ADD → next cycle `ready`=1, `result`=0, `status`=0, `done`=0. A new N=1 ADD 2+3 → 5 with no carry leakage.
